afifo_rd_drain: RTL and testbench
=================================

// Module: afifo_rd_drain
// PURPOSE
// - Read-side drain engine for the async FIFO; lives entirely in the read clock domain.
// - On a start command, pops a burst of words from the FIFO read port (rinc/rempty/rdata).
// - Presents the popped words downstream on a valid/ready stream through a 2-entry skid buffer.
// - Supports counted bursts and a continuous mode, with abort, busy/done status and a word count.
// PARAMETERS
// - DATA_WIDTH  32  width of rdata and m_data
// - LEN_W       16  width of burst_len and word_cnt
// PORTS
// - rclk       in   1           read-domain clock; all logic on rising edge
// - rrst_n     in   1           asynchronous active-low reset
// - rempty     in   1           FIFO empty flag
// - rdata      in   DATA_WIDTH  FIFO head word; show-ahead, valid whenever rempty==0
// - rinc       out  1           FIFO pop strobe; one word popped per cycle while high
// - start      in   1           1-cycle burst request; honoured only in IDLE
// - burst_len  in   LEN_W       words to pop; sampled on start; 0 = continuous mode
// - abort      in   1           stop popping; buffered words are still delivered
// - m_valid    out  1           downstream data valid
// - m_data     out  DATA_WIDTH  downstream data (head of skid buffer)
// - m_ready    in   1           downstream accept; transfer when m_valid && m_ready
// - busy       out  1           high in RUN or DRAIN
// - done       out  1           1-cycle pulse when a burst or abort completes
// - word_cnt   out  LEN_W       words popped in current/last burst
// BEHAVIOUR
// - Reset (async, rrst_n=0):
//   - state=IDLE; rinc=0, m_valid=0, m_data=0, busy=0, done=0, word_cnt=0.
//   - Buffer count=0; buffered words are discarded.
//   - Reset mid-burst aborts with no done pulse.
// - FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE -> RUN on start: latch len=burst_len; clear word_cnt.
//   - IDLE: abort is ignored; start together with abort means start wins.
//   - RUN -> DRAIN when len!=0 and a pop makes word_cnt==len, or when abort=1.
//     On abort, rinc is forced 0 in that same cycle.
//   - RUN in continuous mode (len=0) leaves only on abort.
//   - DRAIN -> DONE when the buffer count is 0, including the same-cycle last handshake.
//   - DONE -> IDLE unconditionally; done=1 for exactly that cycle.
//   - start is ignored outside IDLE.
//   - abort in DRAIN or DONE has no effect.
// - rinc (combinational from registered state):
//   - rinc = (state==RUN) && !rempty && !abort && (cnt<2 || (cnt==2 && m_valid && m_ready)).
//   - With len!=0, rinc is also gated so that word_cnt never exceeds len.
//   - rinc is never high while rempty=1 (underflow is a bench assertion).
// - Skid buffer, 2 entries, FIFO order:
//   - rdata is captured at the rclk edge where rinc=1.
//   - m_valid rises on the next cycle (1-cycle latency).
//   - Push and pop in the same cycle keeps the count unchanged.
//   - m_data stays stable while m_valid && !m_ready.
//   - Throughput is 1 word/cycle with m_ready=1 and FIFO non-empty.
// - word_cnt:
//   - +1 on each rinc.
//   - Holds after DONE until the next start.
//   - Wraps modulo 2^LEN_W in continuous mode.
// - busy = (state==RUN || state==DRAIN).
// - rempty rising mid-burst: popping stalls and the burst resumes when rempty falls; no timeout.
// TESTING
// - Burst basic: FIFO holds 8 words 0x10..0x17, burst_len=4, m_ready=1
//   -> rinc high 4 consecutive cycles; m_data=0x10..0x13 in order.
//   -> word_cnt=4; done pulses once; 4 words remain in FIFO.
// - Backpressure: burst_len=6, m_ready=0 for 10 cycles, then 1
//   -> exactly 2 pops, then rinc=0; m_data held at first word.
//   -> after release, all 6 words are delivered in order with no loss or duplication.
// - Empty stall: burst_len=5 with 2 words in FIFO, 3 more written 20 cycles later
//   -> rinc=0 while rempty=1; all 5 words delivered; done after the 5th handshake.
// - Abort: continuous mode (len=0), 16 words available, abort asserted after the 3rd pop
//   -> rinc low that cycle; buffered words drained.
//   -> done pulses; word_cnt=3; 13 words remain in FIFO.
// - Reset mid-operation: rrst_n low during RUN with 2 buffered words
//   -> all outputs 0 immediately; no done pulse.
//   -> a new start after reset pops from the current FIFO head.
// - Edge cases: start+abort same cycle in IDLE -> burst runs.
//   start during RUN -> ignored, len unchanged.
//   LEN_W=4, continuous mode, 20 pops -> word_cnt=4 (wrap).

Source files
------------

// File: rtl/afifo_rd_drain_if.sv
// Downstream valid/ready stream carrying the words drained from the FIFO.
interface afifo_rd_drain_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/afifo_rd_drain.sv
// Read-domain drain engine: pops counted or continuous bursts from the async
// FIFO read port and hands the words downstream through a 2-entry skid buffer.
module afifo_rd_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  abort,
  afifo_rd_drain_if.master      strm,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [LEN_W-1:0]      len;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;

  logic                  hs;
  logic                  room;
  logic                  len_ok;
  logic                  drain_empty;
  logic [LEN_W-1:0]      cnt_inc;

  assign hs          = strm.m_valid && strm.m_ready;
  // A full buffer still has room when its head leaves this same cycle.
  assign room        = (cnt < 2'd2) || ((cnt == 2'd2) && hs);
  // Counted bursts stop popping once len words have been taken.
  assign len_ok      = (len == '0) || (word_cnt != len);
  assign rinc        = (state == S_RUN) && !rempty && !abort && room && len_ok;
  assign drain_empty = (cnt == 2'd0) || ((cnt == 2'd1) && hs);
  assign cnt_inc     = word_cnt + 1'b1;

  assign strm.m_valid = (cnt != 2'd0);
  assign strm.m_data  = buf_q[rd_ptr];

  // Skid buffer: capture rdata on each pop, retire head on each handshake.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      if (rinc) begin
        buf_q[wr_ptr] <= rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, rinc} - {1'b0, hs};
    end
  end

  // Burst control FSM with registered busy/done and the popped-word counter.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= S_IDLE;
      len      <= '0;
      word_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            len      <= burst_len;
            word_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (rinc) word_cnt <= cnt_inc;
          if (abort || ((len != '0) && rinc && (cnt_inc == len))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_empty) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: FIFO modelled as a data array with read/write
// totals, a queue-based reference model checked every negative edge, directed
// scenarios with literal expectations, then randomized bursts.
module tb_afifo_rd_drain;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rempty;
  logic [31:0] rdata;
  logic        rinc;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [15:0] word_cnt;

  // small-counter instance for the wrap check
  logic        rempty4 = 1'b0;
  logic [31:0] rdata4 = 32'hA5;
  logic        rinc4;
  logic        start4 = 1'b0;
  logic [3:0]  burst_len4 = '0;
  logic        abort4 = 1'b0;
  logic        busy4, done4;
  logic [3:0]  word_cnt4;

  afifo_rd_drain_if #(.DATA_WIDTH(32)) s ();
  afifo_rd_drain_if #(.DATA_WIDTH(32)) s4 ();

  afifo_rd_drain #(.DATA_WIDTH(32), .LEN_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .start(start), .burst_len(burst_len), .abort(abort), .strm(s),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  afifo_rd_drain #(.DATA_WIDTH(32), .LEN_W(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty4), .rdata(rdata4), .rinc(rinc4),
    .start(start4), .burst_len(burst_len4), .abort(abort4), .strm(s4),
    .busy(busy4), .done(done4), .word_cnt(word_cnt4)
  );

  always #5 rclk = ~rclk;

  // FIFO environment: words live in wdata, level = wr_total - rd_total
  logic [31:0] wdata [4096];
  logic [31:0] wr_total = '0;
  logic [31:0] rd_total = '0;
  assign rempty = (rd_total == wr_total);
  assign rdata  = wdata[rd_total[11:0]];
  always @(posedge rclk) if (rinc) rd_total <= rd_total + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  int          ph = P_IDLE;
  logic [15:0] mlen = '0;
  int          mcnt = 0;
  logic [31:0] bq [$];

  // bookkeeping observed at negedges
  int          pops = 0, done_cnt = 0, run = 0, max_run = 0;
  logic [31:0] got_q [$];

  function automatic logic model_rinc();
    return (ph == P_RUN) && !rempty && !abort &&
           ((bq.size() < 2) || (bq.size() == 2 && s.m_ready)) &&
           ((mlen == 0) || (mcnt < int'(mlen)));
  endfunction

  // compare DUT against the model, then advance the model over the next edge
  initial begin
    logic e_rinc, hs;
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        ph = P_IDLE; mlen = '0; mcnt = 0; bq.delete();
      end
      e_rinc = model_rinc();
      chk("rinc", rinc, e_rinc);
      chk("m_valid", s.m_valid, bq.size() != 0);
      if (bq.size() != 0) chk("m_data", s.m_data, bq[0]);
      chk("busy", busy, (ph == P_RUN) || (ph == P_DRAIN));
      chk("done", done, ph == P_DONE);
      chk("word_cnt", word_cnt, mcnt[15:0]);
      chk("underflow", rinc && rempty, 0);
      if (rinc) begin pops++; run++; end else run = 0;
      if (run > max_run) max_run = run;
      if (done) done_cnt++;
      if (s.m_valid && s.m_ready && rrst_n) got_q.push_back(s.m_data);
      if (rrst_n) begin
        hs = (bq.size() != 0) && s.m_ready;
        if (hs) void'(bq.pop_front());
        if (e_rinc) bq.push_back(rdata);
        case (ph)
          P_IDLE:  if (start) begin ph = P_RUN; mlen = burst_len; mcnt = 0; end
          P_RUN: begin
            if (e_rinc) mcnt++;
            if (abort) ph = P_DRAIN;
            else if (mlen != 0 && mcnt == int'(mlen)) ph = P_DRAIN;
          end
          P_DRAIN: if (bq.size() == 0) ph = P_DONE;
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic fifo_write(input int n, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wdata[wr_total[11:0]] = rnd ? $urandom : base + i;
      wr_total = wr_total + 1;
    end
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1; burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk(nm, done_cnt != d0, 1);
  endtask

  task automatic chk_got(input string nm, input int n, input logic [31:0] idx0);
    chk({nm, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({nm, "_word"}, got_q[i], wdata[(idx0 + i) % 4096]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] idx0;
    int p0, d0, n, len, p;
    bit seen;
    s.m_ready = 1'b0;
    s4.m_ready = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", s.m_valid, 0);
    chk("rst_m_data", s.m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rrst_n = 1'b1;
    tick();

    // basic burst: 8 words 0x10..0x17, len 4
    fifo_write(8, 32'h10, 0);
    s.m_ready = 1'b1;
    got_q.delete(); max_run = 0; d0 = done_cnt;
    do_start(16'd4);
    wait_done("basic_done", 40);
    chk("basic_run", max_run, 4);
    chk("basic_word_cnt", word_cnt, 4);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_level", wr_total - rd_total, 4);
    chk("basic_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h10);
    chk("basic_w3", got_q.size() > 3 ? got_q[3] : 32'hx, 32'h13);
    chk_got("basic", 4, 32'd0);

    // backpressure: len 6, m_ready low 10 cycles
    fifo_write(4, 0, 1);
    s.m_ready = 1'b0;
    got_q.delete(); idx0 = rd_total; p0 = pops;
    do_start(16'd6);
    repeat (10) tick();
    chk("bp_pops", pops - p0, 2);
    chk("bp_rinc", rinc, 0);
    chk("bp_hold_data", s.m_data, wdata[idx0[11:0]]);
    s.m_ready = 1'b1;
    wait_done("bp_done", 40);
    chk_got("bp", 6, idx0);
    chk("bp_level", wr_total - rd_total, 2);

    // empty stall: 2 words present, 3 more arrive 20 cycles later
    got_q.delete(); idx0 = rd_total; p0 = pops;
    do_start(16'd5);
    repeat (20) tick();
    chk("stall_pops", pops - p0, 2);
    chk("stall_busy", busy, 1);
    fifo_write(3, 0, 1);
    wait_done("stall_done", 40);
    chk_got("stall", 5, idx0);
    chk("stall_word_cnt", word_cnt, 5);

    // abort in continuous mode after the 3rd pop
    fifo_write(16, 32'h100, 0);
    got_q.delete(); idx0 = rd_total; p0 = pops; d0 = done_cnt; n = 0;
    do_start(16'd0);
    while (pops - p0 < 3 && n < 50) begin tick(); n++; end
    abort = 1'b1;
    #1;
    chk("abort_rinc", rinc, 0);
    tick();
    abort = 1'b0;
    wait_done("abort_done", 40);
    chk("abort_word_cnt", word_cnt, 3);
    chk("abort_level", wr_total - rd_total, 13);
    chk("abort_done_once", done_cnt - d0, 1);
    chk_got("abort", 3, idx0);

    // reset with 2 words buffered
    s.m_ready = 1'b0;
    p0 = pops; n = 0;
    do_start(16'd8);
    while (pops - p0 < 2 && n < 50) begin tick(); n++; end
    d0 = done_cnt;
    rrst_n = 1'b0;
    #1;
    chk("mrst_outs", {rinc, s.m_valid, busy, done}, 0);
    chk("mrst_m_data", s.m_data, 0);
    chk("mrst_word_cnt", word_cnt, 0);
    repeat (2) tick();
    rrst_n = 1'b1;
    tick();
    chk("mrst_no_done", done_cnt - d0, 0);
    s.m_ready = 1'b1;
    got_q.delete(); idx0 = rd_total;
    do_start(16'd3);
    wait_done("mrst_done", 40);
    chk_got("mrst", 3, idx0);
    chk("mrst_level", wr_total - rd_total, 8);

    // start together with abort in IDLE: start wins
    start = 1'b1; abort = 1'b1; burst_len = 16'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1);
    wait_done("sa_done", 40);
    chk("sa_word_cnt", word_cnt, 2);

    // start during RUN is ignored
    s.m_ready = 1'b0;
    do_start(16'd3);
    tick();
    do_start(16'd7);
    s.m_ready = 1'b1;
    wait_done("srun_done", 40);
    chk("srun_word_cnt", word_cnt, 3);
    chk("srun_level", wr_total - rd_total, 3);

    // randomized bursts
    for (int it = 0; it < 40; it++) begin
      fifo_write($urandom_range(0, 6), 0, 1);
      len = $urandom_range(0, 5);
      d0 = done_cnt; n = 0;
      do_start(16'(len));
      while (done_cnt == d0 && n < 80) begin
        s.m_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) fifo_write(1, 0, 1);
        abort = (n > 30) && ($urandom_range(0, 4) == 0);
        tick();
        n++;
      end
      abort = 1'b0;
      if (done_cnt == d0) begin
        s.m_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("rnd_done", 40);
      end
    end

    // 4-bit counter wraps in continuous mode: 20 pops -> 4
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    p = 0; n = 0;
    while (p < 20 && n < 100) begin
      if (rinc4) p++;
      tick();
      n++;
    end
    abort4 = 1'b1;
    #1;
    chk("wrap_abort_rinc", rinc4, 0);
    tick();
    abort4 = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      if (done4) seen = 1;
      tick();
      n++;
    end
    chk("wrap_done", seen, 1);
    chk("wrap_word_cnt", word_cnt4, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
